muldiv_sequencer: RTL and testbench
===================================

# muldiv_sequencer

Multi-cycle RV32M multiply/divide unit with its own sequencing FSM, placed beside the main ALU in the execute stage. The decoder routes OP instructions with Funct7 = 0000001 here instead of to the ALU. The block latches operands on a start pulse, iterates one bit per cycle, applies RISC-V sign/special-case rules and pulses done with the result. It drives a stall so the pipeline holds the instruction until the result is ready.

## Interface
- WIDTH, 32, operand/result width; iteration count equals WIDTH
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high; returns block to IDLE
- start  in  1  request; sampled only in IDLE
- Funct3  in  3  op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- SrcA  in  WIDTH  rs1 value (multiplicand / dividend)
- SrcB  in  WIDTH  rs2 value (multiplier / divisor)
- flush  in  1  abort current op (branch/jump flush)
- busy  out  1  high while state = BUSY
- done  out  1  one-cycle pulse, Result valid
- Result  out  WIDTH  registered result; holds until next accepted start
- stall  out  1  combinational: (start & state==IDLE & ~flush) | (state==BUSY)

## Operation
- States: IDLE, BUSY, DONE. Reset: IDLE, busy 0, done 0, Result 0, internal regs 0.
- IDLE + start (& ~flush): latch Funct3, magnitudes |SrcA|, |SrcB| (signed only where op treats operand as signed: MULH both, MULHSU SrcA only, DIV/REM both), result sign flags, counter = WIDTH.
  - Divide by zero (SrcB = 0, ops 1xx): fast path -> DONE; quotient = all ones (DIV and DIVU), remainder = SrcA.
  - Signed overflow (DIV/REM, SrcA = 100..0, SrcB = all ones): fast path -> DONE; quotient = SrcA, remainder = 0.
  - Otherwise -> BUSY.
- BUSY, multiply: shift-add, 2*WIDTH-bit accumulator, one multiplier bit per cycle, LSB first.
- BUSY, divide: restoring, one quotient bit per cycle, MSB first; WIDTH+1-bit partial remainder.
- Counter decrements each BUSY cycle. On the last iteration Result is loaded with the sign-corrected value and state -> DONE:
  - MUL: low WIDTH bits of product.
  - MULH/MULHSU/MULHU: high WIDTH bits of two's-complement product (negate full 2*WIDTH product when signs differ).
  - DIV: quotient negated if operand signs differ. REM: remainder takes dividend's sign.
- DONE: done = 1 for exactly one cycle, then -> IDLE unconditionally.
- start in BUSY or DONE is ignored (no queueing).
- flush in BUSY: -> IDLE next edge; no done; Result unchanged.
- flush in IDLE with start: start dropped, stall 0.
- flush in DONE: done still pulses (result already committed by pipeline).
- reset at any time: immediate IDLE, in-flight op discarded, Result cleared.

## Timing
- start high in cycle 0 (IDLE) -> BUSY cycles 1..WIDTH -> done and Result valid in cycle WIDTH+1 (33 for WIDTH=32).
- Fast paths: done in cycle 1.
- stall high cycles 0..WIDTH; low in the done cycle, so the pipeline writes back Result in that cycle.
- Result registered; valid from the done cycle until the next accepted start's done cycle. Not overwritten by aborted ops.
- Back-to-back: a new start is accepted at the earliest in the cycle after DONE.

## Test plan
- MUL SrcA=7, SrcB=0xFFFFFFFD -> done in cycle 33, Result=0xFFFFFFEB. MULHU on the same operands -> 0x00000006. MULH 0x80000000 x 0x80000000 -> 0x40000000.
- DIVU 100/7 -> 14; REMU -> 2. DIV 0xFFFFFFF9/2 -> 0xFFFFFFFD; REM -> 0xFFFFFFFF. All return done in cycle 33 with stall high cycles 0..32.
- DIV 5/0 -> done cycle 1, Result=0xFFFFFFFF. REM 5/0 -> 5. DIV 0x80000000/0xFFFFFFFF -> 0x80000000 in cycle 1; REM -> 0.
- Start DIVU in cycle 0, flush in cycle 10 -> IDLE in cycle 11, no done pulse, Result keeps previous value. New start in cycle 11 completes normally.
- Assert reset asynchronously mid-BUSY -> busy, done, stall, Result = 0 immediately. Start pulses during BUSY are ignored, and exactly one done is produced per accepted start.
- Randomized: 1000 ops covering all Funct3 values and corner operands (0, 1, all ones, 0x80000000, 0x7FFFFFFF), compared against a reference model. Check stall and done timing on every op.

Source files
------------

// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer
//   Multi-cycle RV32M multiply/divide unit that sits beside the execute-stage
//   ALU. Operands are latched on an accepted start. The unit then works one
//   bit per cycle: shift-add for multiply, restoring division for divide.
//   Sign correction is applied on the final iteration. Result is registered,
//   and done pulses for one cycle. stall holds the pipeline from the request
//   cycle until the cycle before done.
//
// Ports
//   clk     in   rising-edge clock
//   reset   in   asynchronous active-high reset
//   start   in   operation request, sampled only in IDLE
//   Funct3  in   000 MUL, 001 MULH, 010 MULHSU, 011 MULHU,
//                100 DIV, 101 DIVU, 110 REM, 111 REMU
//   SrcA    in   rs1: multiplicand / dividend
//   SrcB    in   rs2: multiplier / divisor
//   flush   in   abort an in-flight op; also drops a start that arrives in IDLE
//   busy    out  iterating
//   done    out  one-cycle pulse, Result valid
//   Result  out  registered result, held until the next accepted op completes
//   stall   out  pipeline hold request (combinational)
//
// state | meaning
// IDLE  | waiting for start
// BUSY  | iterating, one bit per cycle; the counter runs WIDTH down to 1
// DONE  | Result valid, done pulses; returns to IDLE unconditionally

module muldiv_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       Funct3,
    input  logic [WIDTH-1:0] SrcA,
    input  logic [WIDTH-1:0] SrcB,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Result,
    output logic             stall
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]       state;
    logic [2:0]       op;
    logic [WIDTH-1:0] opnd;     // multiplicand (mul) or divisor (div)
    logic [WIDTH-1:0] acc_hi;   // product high half or partial remainder
    logic [WIDTH-1:0] acc_lo;   // multiplier/product low, or dividend/quotient
    logic [CW-1:0]    cnt;
    logic             neg_q;    // product or quotient must be negated
    logic             neg_r;    // remainder must be negated (dividend sign)

    // ---------------- request decode ----------------
    logic             is_div_in, sgn_a_in, sgn_b_in, neg_a_in, neg_b_in;
    logic [WIDTH-1:0] mag_a, mag_b;
    logic             div_zero_in, div_ovf_in, accept;
    logic [WIDTH-1:0] fast_result;

    always_comb begin
        is_div_in   = Funct3[2];
        sgn_a_in    = (Funct3 == 3'b001) || (Funct3 == 3'b010) ||
                      (Funct3 == 3'b100) || (Funct3 == 3'b110);
        sgn_b_in    = (Funct3 == 3'b001) || (Funct3 == 3'b100) ||
                      (Funct3 == 3'b110);
        neg_a_in    = sgn_a_in & SrcA[WIDTH-1];
        neg_b_in    = sgn_b_in & SrcB[WIDTH-1];
        // The most negative value maps onto itself, which is its correct
        // unsigned magnitude.
        mag_a       = neg_a_in ? ({WIDTH{1'b0}} - SrcA) : SrcA;
        mag_b       = neg_b_in ? ({WIDTH{1'b0}} - SrcB) : SrcB;
        div_zero_in = is_div_in && (SrcB == {WIDTH{1'b0}});
        div_ovf_in  = is_div_in && sgn_a_in &&
                      (SrcA == {1'b1, {(WIDTH-1){1'b0}}}) &&
                      (SrcB == {WIDTH{1'b1}});
        accept      = (state == IDLE) && start && !flush;

        // Funct3[1] selects a remainder result within the divide group.
        fast_result = '0;
        if (div_zero_in)
            fast_result = Funct3[1] ? SrcA : {WIDTH{1'b1}};
        else if (div_ovf_in)
            fast_result = Funct3[1] ? {WIDTH{1'b0}} : SrcA;
    end

    // ---------------- one iteration ----------------
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH-1:0] mul_hi_nx, mul_lo_nx;
    logic [WIDTH:0]   div_shift;
    logic             div_ge;
    logic [WIDTH-1:0] div_hi_nx, div_lo_nx;

    always_comb begin
        mul_sum   = {1'b0, acc_hi} + {1'b0, (acc_lo[0] ? opnd : {WIDTH{1'b0}})};
        mul_hi_nx = mul_sum[WIDTH:1];
        mul_lo_nx = {mul_sum[0], acc_lo[WIDTH-1:1]};

        // Partial remainder stays below the divisor, so the W-bit difference
        // is exact whenever the trial subtraction succeeds.
        div_shift = {acc_hi, acc_lo[WIDTH-1]};
        div_ge    = (div_shift >= {1'b0, opnd});
        div_hi_nx = div_ge ? (div_shift[WIDTH-1:0] - opnd) : div_shift[WIDTH-1:0];
        div_lo_nx = {acc_lo[WIDTH-2:0], div_ge};
    end

    // ---------------- sign-corrected final result ----------------
    logic [2*WIDTH-1:0] prod, prod_s;
    logic [WIDTH-1:0]   quot_s, rem_s;
    logic [WIDTH-1:0]   final_result;

    always_comb begin
        prod   = {mul_hi_nx, mul_lo_nx};
        prod_s = neg_q ? ({(2*WIDTH){1'b0}} - prod) : prod;
        quot_s = neg_q ? ({WIDTH{1'b0}} - div_lo_nx) : div_lo_nx;
        rem_s  = neg_r ? ({WIDTH{1'b0}} - div_hi_nx) : div_hi_nx;
        case (op)
            3'b000:                 final_result = prod_s[WIDTH-1:0];
            3'b001, 3'b010, 3'b011: final_result = prod_s[2*WIDTH-1:WIDTH];
            3'b100, 3'b101:         final_result = quot_s;
            default:                final_result = rem_s;
        endcase
    end

    // ---------------- sequencer ----------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            op     <= '0;
            opnd   <= '0;
            acc_hi <= '0;
            acc_lo <= '0;
            cnt    <= '0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            Result <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        op     <= Funct3;
                        neg_q  <= neg_a_in ^ neg_b_in;
                        neg_r  <= neg_a_in;
                        opnd   <= is_div_in ? mag_b : mag_a;
                        acc_lo <= is_div_in ? mag_a : mag_b;
                        acc_hi <= '0;
                        cnt    <= CNT_INIT;
                        if (div_zero_in || div_ovf_in) begin
                            Result <= fast_result;
                            state  <= DONE;
                        end else begin
                            state  <= BUSY;
                        end
                    end
                end
                BUSY: begin
                    if (flush) begin
                        state <= IDLE;
                    end else begin
                        acc_hi <= op[2] ? div_hi_nx : mul_hi_nx;
                        acc_lo <= op[2] ? div_lo_nx : mul_lo_nx;
                        cnt    <= cnt - CNT_ONE;
                        if (cnt == CNT_ONE) begin
                            Result <= final_result;
                            state  <= DONE;
                        end
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign busy  = (state == BUSY);
    assign done  = (state == DONE);
    assign stall = (start && (state == IDLE) && !flush) || (state == BUSY);

endmodule

// File: tb/tb_muldiv_sequencer.sv
module tb_muldiv_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  Funct3;
    logic [31:0] SrcA, SrcB;
    logic        flush;
    logic        busy, done, stall;
    logic [31:0] Result;

    int n_checks = 0;
    int n_pass   = 0;

    muldiv_sequencer #(.WIDTH(32)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .Funct3 (Funct3),
        .SrcA   (SrcA),
        .SrcB   (SrcB),
        .flush  (flush),
        .busy   (busy),
        .done   (done),
        .Result (Result),
        .stall  (stall)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        longint      sa, sb, t;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (f)
            3'b000: begin p = {32'b0, a} * {32'b0, b}; return p[31:0]; end
            3'b001: begin t = sa * sb; p = t; return p[63:32]; end
            3'b010: begin t = sa * longint'({32'b0, b}); p = t; return p[63:32]; end
            3'b011: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
            3'b100: begin
                if (b == 0) return 32'hFFFF_FFFF;
                t = sa / sb; p = t; return p[31:0];
            end
            3'b101: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'b110: begin
                if (b == 0) return a;
                t = sa % sb; p = t; return p[31:0];
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int latency(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        if (f[2] && (b == 0 || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)))
            return 1;
        return 33;
    endfunction

    // Called at (or just after) a falling edge: drives the request in cycle 0
    // and follows the op until two cycles past its expected done.
    task automatic run_op(input string tag, input logic [2:0] f, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input bit hold);
        int          lat, dcyc, dcnt, stall_err;
        logic [31:0] res;
        lat    = latency(f, a, b);
        Funct3 = f; SrcA = a; SrcB = b; start = 1'b1;
        #1;
        stall_err = (stall !== 1'b1) ? 1 : 0;
        dcyc = -1; dcnt = 0; res = Result;
        for (int k = 1; k <= lat + 2; k++) begin
            @(negedge clk);
            start = hold && (k < lat);
            SrcA  = ~a;          // operands must already be latched
            SrcB  = a ^ b;
            Funct3 = ~f;
            #1;
            if (stall !== (k < lat)) stall_err++;
            if (done === 1'b1) begin
                dcnt++;
                if (dcyc < 0) begin dcyc = k; res = Result; end
            end
        end
        check({tag, " result"}, res, exp);
        check({tag, " done_cycle"}, 32'(dcyc), 32'(lat));
        check({tag, " stall"}, 32'(stall_err), 32'd0);
        check({tag, " done_count"}, 32'(dcnt), 32'd1);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 6))
            0: return 32'h0000_0000;
            1: return 32'h0000_0001;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'h7FFF_FFFF;
            5: return 32'($urandom_range(0, 300)) - 32'd150;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        logic [2:0]  rf;
        logic [31:0] ra, rb;

        reset = 1'b1; start = 1'b0; flush = 1'b0;
        Funct3 = '0; SrcA = '0; SrcB = '0;
        repeat (2) @(negedge clk);
        #1;
        check("rst busy", 32'(busy), 32'd0);
        check("rst done", 32'(done), 32'd0);
        check("rst stall", 32'(stall), 32'd0);
        check("rst result", Result, 32'd0);
        reset = 1'b0;

        @(negedge clk); run_op("MUL", 3'b000, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0);
        @(negedge clk); run_op("MULHU", 3'b011, 32'd7, 32'hFFFF_FFFD, 32'h0000_0006, 1'b0);
        @(negedge clk); run_op("MULH min", 3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 1'b0);
        @(negedge clk); run_op("MULHSU", 3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        @(negedge clk); run_op("MULH neg", 3'b001, 32'hFFFF_FFFF, 32'd5, 32'hFFFF_FFFF, 1'b0);
        @(negedge clk); run_op("DIVU", 3'b101, 32'd100, 32'd7, 32'd14, 1'b0);
        @(negedge clk); run_op("REMU", 3'b111, 32'd100, 32'd7, 32'd2, 1'b0);
        @(negedge clk); run_op("DIV neg", 3'b100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 1'b0);
        @(negedge clk); run_op("REM neg", 3'b110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 1'b0);
        @(negedge clk); run_op("DIV by0", 3'b100, 32'd5, 32'd0, 32'hFFFF_FFFF, 1'b0);
        @(negedge clk); run_op("REM by0", 3'b110, 32'd5, 32'd0, 32'd5, 1'b0);
        @(negedge clk); run_op("DIVU by0", 3'b101, 32'd9, 32'd0, 32'hFFFF_FFFF, 1'b0);
        @(negedge clk); run_op("DIV ovf", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0);
        @(negedge clk); run_op("REM ovf", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1'b0);
        @(negedge clk); run_op("DIVU big", 3'b101, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1'b0);
        @(negedge clk); run_op("DIVU hold", 3'b101, 32'd100, 32'd7, 32'd14, 1'b1);
        @(negedge clk); run_op("DIV0 hold", 3'b100, 32'd5, 32'd0, 32'hFFFF_FFFF, 1'b1);
        @(negedge clk); run_op("DIVU prev", 3'b101, 32'd100, 32'd7, 32'd14, 1'b0);

        // flush mid-BUSY: start in cycle 0, flush in cycle 10
        @(negedge clk);
        Funct3 = 3'b101; SrcA = 32'd1000; SrcB = 32'd3; start = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            start = 1'b0;
            if (k == 10) flush = 1'b1;
            #1;
            if (k == 10) check("flush busy c10", 32'(busy), 32'd1);
        end
        @(negedge clk);
        flush = 1'b0;
        #1;
        check("flush busy c11", 32'(busy), 32'd0);
        check("flush done c11", 32'(done), 32'd0);
        check("flush result kept", Result, 32'd14);
        run_op("after flush", 3'b100, 32'd1000, 32'hFFFF_FFFD, 32'hFFFF_FEB3, 1'b0);

        // flush together with start in IDLE drops the request
        @(negedge clk);
        Funct3 = 3'b101; SrcA = 32'd50; SrcB = 32'd5; start = 1'b1; flush = 1'b1;
        #1;
        check("idle flush stall", 32'(stall), 32'd0);
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        #1;
        check("idle flush busy", 32'(busy), 32'd0);
        check("idle flush done", 32'(done), 32'd0);

        // flush during DONE does not suppress the pulse
        @(negedge clk);
        Funct3 = 3'b110; SrcA = 32'd77; SrcB = 32'd0; start = 1'b1;
        @(negedge clk);
        start = 1'b0; flush = 1'b1;
        #1;
        check("done flush pulse", 32'(done), 32'd1);
        check("done flush result", Result, 32'd77);
        @(negedge clk);
        flush = 1'b0;
        #1;
        check("done flush after", 32'(done), 32'd0);

        // asynchronous reset mid-BUSY
        @(negedge clk);
        Funct3 = 3'b000; SrcA = 32'd12; SrcB = 32'd12; start = 1'b1;
        repeat (5) begin @(negedge clk); start = 1'b0; end
        #2;
        reset = 1'b1;
        #1;
        check("areset busy", 32'(busy), 32'd0);
        check("areset done", 32'(done), 32'd0);
        check("areset stall", 32'(stall), 32'd0);
        check("areset result", Result, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk); run_op("after reset", 3'b000, 32'd12, 32'd12, 32'd144, 1'b0);

        for (int i = 0; i < 1000; i++) begin
            rf = 3'($urandom_range(0, 7));
            ra = pick();
            rb = pick();
            @(negedge clk);
            run_op($sformatf("rnd%0d f%0d %h %h", i, rf, ra, rb), rf, ra, rb, model(rf, ra, rb), 1'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
